// File: rtl/bv4_sq_scl_pipe.sv
// bv4_sq_scl_pipe: masked, multi-lane, pipelined GF(2^4) square-and-scale.
// Each 4-bit element is {a1,a0}, where a1 and a0 are GF(2^2) normal-basis digits.
//   mode 0: b = {sq(a0)^sq(a1), sigma2(sq(a0))}
//   mode 1: b = {sq(a1), sq(a0)}
// The map is linear, so it is applied to each share on its own.
// Optional feature: define BV4_SQ_SCL_PIPE_REFRESH_EN to re-mask the shares with in_rand.
// In the default build in_rand is present but unused.

// Single share element; no cross-share logic lives here.
module bv4_sq_scl_lane (
  input  logic       mode,
  input  logic [3:0] a,
  output logic [3:0] b
);
  logic [1:0] s0, s1, sig;

  // In a normal basis, squaring is a swap of the two digit bits.
  assign s0  = {a[0], a[1]};
  assign s1  = {a[2], a[3]};
  // Multiply by sigma^2 (sigma = W, basis {W, W^2}): {x1,x0} -> {x1^x0, x1}.
  assign sig = {s0[1] ^ s0[0], s0[1]};
  assign b   = mode ? {s1, s0} : {s0 ^ s1, sig};
endmodule

module bv4_sq_scl_pipe #(
  parameter  int N_LANES     = 1,
  parameter  int N_SHARES    = 2,
  parameter  int PIPE_STAGES = 1,
  localparam int DW = 4 * N_SHARES * N_LANES,
  localparam int RW = (N_SHARES > 1) ? 4 * (N_SHARES - 1) * N_LANES : 1,
  localparam int CW = $clog2(PIPE_STAGES + 1)
) (
  input  logic          in_clock,
  input  logic          in_reset,
  input  logic          in_valid,
  output logic          out_ready,
  input  logic          in_mode,
  input  logic [DW-1:0] in_a,
  input  logic [RW-1:0] in_rand,
  output logic          out_valid,
  input  logic          in_ready,
  output logic [DW-1:0] out_b,
  output logic [CW-1:0] out_count
);
  typedef logic [N_LANES-1:0][N_SHARES-1:0][3:0] shr_t;

  shr_t a_p, f_p, d_in;
  shr_t data_pipe [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_pipe, ld;
  logic [CW-1:0] cnt;
  logic acc, drain;

  assign a_p = in_a;

  // The function is evaluated once, ahead of stage 0. Mode therefore travels
  // down the pipe already folded into the data.
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    for (genvar s = 0; s < N_SHARES; s++) begin : g_shr
      bv4_sq_scl_lane u_lane (.mode(in_mode), .a(a_p[l][s]), .b(f_p[l][s]));
    end
  end

`ifdef BV4_SQ_SCL_PIPE_REFRESH_EN
  if (N_SHARES > 1) begin : g_rfr
    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
      logic [N_SHARES-2:0][3:0] r;
      logic [3:0] r_sum;
      assign r = in_rand[l*4*(N_SHARES-1) +: 4*(N_SHARES-1)];

      // The last share absorbs the XOR of all masks, so the share-sum is unchanged.
      always_comb begin
        r_sum = '0;
        for (int i = 0; i < N_SHARES - 1; i++) r_sum = r_sum ^ r[i];
      end

      for (genvar s = 0; s < N_SHARES; s++) begin : g_shr
        if (s < N_SHARES - 1) begin : g_mid
          assign d_in[l][s] = f_p[l][s] ^ r[s];
        end else begin : g_last
          assign d_in[l][s] = f_p[l][s] ^ r_sum;
        end
      end
    end
  end else begin : g_nofr
    logic unused_rand;
    assign unused_rand = ^in_rand;
    assign d_in = f_p;
  end
`else
  logic unused_rand;
  assign unused_rand = ^in_rand;
  assign d_in = f_p;
`endif

  // Stage k may load unless it and every stage below it are full while the sink stalls.
  // This is the flattened form of the ready chain, so it has no combinational loop.
  always_comb begin
    ld = '0;
    for (int k = 0; k < PIPE_STAGES; k++)
      ld[k] = in_ready || !(&(vld_pipe | PIPE_STAGES'((1 << k) - 1)));
  end

  assign out_ready = ld[0] && !in_reset;
  assign acc       = in_valid && out_ready;
  assign out_valid = vld_pipe[PIPE_STAGES-1];
  assign drain     = out_valid && in_ready;
  assign out_b     = data_pipe[PIPE_STAGES-1];
  assign out_count = cnt;

  // Elastic pipe: a stage takes its upstream neighbour's contents whenever it may load.
  // Data is loaded only with a valid beat, so out_b holds while the output is idle.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      vld_pipe <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) data_pipe[k] <= '0;
    end else begin
      if (ld[0]) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) data_pipe[0] <= d_in;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (ld[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
        end
      end
    end
  end

  // Occupancy counter: it moves only when exactly one of accept and drain happens.
  always_ff @(posedge in_clock) begin
    if (in_reset)            cnt <= '0;
    else if (acc && !drain)  cnt <= cnt + 1'b1;
    else if (drain && !acc)  cnt <= cnt - 1'b1;
  end
endmodule
